// File: rtl/axi_lite_arbiter_2m.sv
// Two-requester AXI4-Lite arbiter in front of the interconnect master port.
// Write and read channels arbitrate independently (round-robin) and hold the grant until completion.
module axi_lite_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [1:0]                  i_s_axi_awvalid,
  input  logic [2*ADDR_WIDTH-1:0]     i_s_axi_awaddr,
  input  logic [5:0]                  i_s_axi_awprot,
  input  logic [1:0]                  i_s_axi_wvalid,
  input  logic [2*DATA_WIDTH-1:0]     i_s_axi_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0] i_s_axi_wstrb,
  input  logic [1:0]                  i_s_axi_bready,
  input  logic [1:0]                  i_s_axi_arvalid,
  input  logic [2*ADDR_WIDTH-1:0]     i_s_axi_araddr,
  input  logic [5:0]                  i_s_axi_arprot,
  input  logic [1:0]                  i_s_axi_rready,
  output logic [1:0]                  o_s_axi_awready,
  output logic [1:0]                  o_s_axi_wready,
  output logic [1:0]                  o_s_axi_bvalid,
  output logic [1:0]                  o_s_axi_arready,
  output logic [1:0]                  o_s_axi_rvalid,
  output logic [2*DATA_WIDTH-1:0]     o_s_axi_rdata,
  output logic                        o_m_axi_awvalid,
  output logic [ADDR_WIDTH-1:0]       o_m_axi_awaddr,
  output logic [2:0]                  o_m_axi_awprot,
  output logic                        o_m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]       o_m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]     o_m_axi_wstrb,
  output logic                        o_m_axi_bready,
  output logic                        o_m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]       o_m_axi_araddr,
  output logic [2:0]                  o_m_axi_arprot,
  output logic                        o_m_axi_rready,
  input  logic                        i_m_axi_awready,
  input  logic                        i_m_axi_wready,
  input  logic                        i_m_axi_bvalid,
  input  logic                        i_m_axi_arready,
  input  logic                        i_m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]       i_m_axi_rdata,
  output logic                        o_wgrant,
  output logic                        o_rgrant,
  output logic                        o_wbusy,
  output logic                        o_rbusy
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic wgrant_q, wgrant_d, wlast_q, wlast_d;
  logic rgrant_q, rgrant_d, rlast_q, rlast_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic wpick, rpick, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // On a tie the requester that did not finish last wins.
  assign wpick = (&i_s_axi_awvalid) ? ~wlast_q : i_s_axi_awvalid[1];
  assign rpick = (&i_s_axi_arvalid) ? ~rlast_q : i_s_axi_arvalid[1];

  assign o_m_axi_awvalid = (wstate_q == W_ADDR) && !aw_done_q && i_s_axi_awvalid[wgrant_q];
  assign o_m_axi_wvalid  = (wstate_q == W_ADDR) && !w_done_q && i_s_axi_wvalid[wgrant_q];
  assign o_m_axi_bready  = (wstate_q == W_RESP) && i_s_axi_bready[wgrant_q];
  assign o_m_axi_arvalid = (rstate_q == R_ADDR) && i_s_axi_arvalid[rgrant_q];
  assign o_m_axi_rready  = (rstate_q == R_DATA) && i_s_axi_rready[rgrant_q];

  assign aw_hs = o_m_axi_awvalid && i_m_axi_awready;
  assign w_hs  = o_m_axi_wvalid && i_m_axi_wready;
  assign b_hs  = o_m_axi_bready && i_m_axi_bvalid;
  assign ar_hs = o_m_axi_arvalid && i_m_axi_arready;
  assign r_hs  = o_m_axi_rready && i_m_axi_rvalid;

  assign o_m_axi_awaddr = wgrant_q ? i_s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_s_axi_awaddr[ADDR_WIDTH-1:0];
  assign o_m_axi_awprot = wgrant_q ? i_s_axi_awprot[5:3] : i_s_axi_awprot[2:0];
  assign o_m_axi_wdata  = wgrant_q ? i_s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_s_axi_wdata[DATA_WIDTH-1:0];
  assign o_m_axi_wstrb  = wgrant_q ? i_s_axi_wstrb[2*SW-1:SW] : i_s_axi_wstrb[SW-1:0];
  assign o_m_axi_araddr = rgrant_q ? i_s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_s_axi_araddr[ADDR_WIDTH-1:0];
  assign o_m_axi_arprot = rgrant_q ? i_s_axi_arprot[5:3] : i_s_axi_arprot[2:0];

  // Upstream returns depend only on state, grant and downstream signals.
  always_comb begin
    o_s_axi_awready = '0;
    o_s_axi_wready  = '0;
    o_s_axi_bvalid  = '0;
    o_s_axi_arready = '0;
    o_s_axi_rvalid  = '0;
    o_s_axi_rdata   = '0;
    o_s_axi_awready[wgrant_q] = (wstate_q == W_ADDR) && !aw_done_q && i_m_axi_awready;
    o_s_axi_wready[wgrant_q]  = (wstate_q == W_ADDR) && !w_done_q && i_m_axi_wready;
    o_s_axi_bvalid[wgrant_q]  = (wstate_q == W_RESP) && i_m_axi_bvalid;
    o_s_axi_arready[rgrant_q] = (rstate_q == R_ADDR) && i_m_axi_arready;
    o_s_axi_rvalid[rgrant_q]  = (rstate_q == R_DATA) && i_m_axi_rvalid;
    if (rgrant_q) o_s_axi_rdata[2*DATA_WIDTH-1:DATA_WIDTH] = i_m_axi_rdata;
    else          o_s_axi_rdata[DATA_WIDTH-1:0]            = i_m_axi_rdata;
  end

  always_comb begin
    wstate_d  = wstate_q;
    wgrant_d  = wgrant_q;
    wlast_d   = wlast_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wstate_q)
      W_IDLE: if (|i_s_axi_awvalid) begin
        wgrant_d = wpick;
        wstate_d = W_ADDR;
      end
      W_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: if (b_hs) begin
        wlast_d  = wgrant_q;
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rgrant_d = rgrant_q;
    rlast_d  = rlast_q;
    case (rstate_q)
      R_IDLE: if (|i_s_axi_arvalid) begin
        rgrant_d = rpick;
        rstate_d = R_ADDR;
      end
      R_ADDR: if (ar_hs) rstate_d = R_DATA;
      R_DATA: if (r_hs) begin
        rlast_d  = rgrant_q;
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wgrant_q  <= 1'b0;
      rgrant_q  <= 1'b0;
      wlast_q   <= 1'b1;
      rlast_q   <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wgrant_q  <= wgrant_d;
      rgrant_q  <= rgrant_d;
      wlast_q   <= wlast_d;
      rlast_q   <= rlast_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign o_wgrant = wgrant_q;
  assign o_rgrant = rgrant_q;
  assign o_wbusy  = (wstate_q != W_IDLE);
  assign o_rbusy  = (rstate_q != R_IDLE);
endmodule

// File: tb/tb_axi_lite_arbiter_2m.sv
// Directed bench for axi_lite_arbiter_2m: bench drives both requesters and the downstream slave.
module tb_axi_lite_arbiter_2m;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [1:0]      s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [2*AW-1:0] s_awaddr, s_araddr;
  logic [5:0]      s_awprot, s_arprot;
  logic [2*DW-1:0] s_wdata;
  logic [7:0]      s_wstrb;
  logic [1:0]      s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [2*DW-1:0] s_rdata;
  logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic [DW-1:0]   m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            wgrant, rgrant, wbusy, rbusy;

  int n_cmp = 0;
  int n_err = 0;
  int aw_cnt = 0;
  int w_cnt = 0;

  axi_lite_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .i_s_axi_awvalid(s_awvalid), .i_s_axi_awaddr(s_awaddr), .i_s_axi_awprot(s_awprot),
    .i_s_axi_wvalid(s_wvalid), .i_s_axi_wdata(s_wdata), .i_s_axi_wstrb(s_wstrb),
    .i_s_axi_bready(s_bready), .i_s_axi_arvalid(s_arvalid), .i_s_axi_araddr(s_araddr),
    .i_s_axi_arprot(s_arprot), .i_s_axi_rready(s_rready),
    .o_s_axi_awready(s_awready), .o_s_axi_wready(s_wready), .o_s_axi_bvalid(s_bvalid),
    .o_s_axi_arready(s_arready), .o_s_axi_rvalid(s_rvalid), .o_s_axi_rdata(s_rdata),
    .o_m_axi_awvalid(m_awvalid), .o_m_axi_awaddr(m_awaddr), .o_m_axi_awprot(m_awprot),
    .o_m_axi_wvalid(m_wvalid), .o_m_axi_wdata(m_wdata), .o_m_axi_wstrb(m_wstrb),
    .o_m_axi_bready(m_bready), .o_m_axi_arvalid(m_arvalid), .o_m_axi_araddr(m_araddr),
    .o_m_axi_arprot(m_arprot), .o_m_axi_rready(m_rready),
    .i_m_axi_awready(m_awready), .i_m_axi_wready(m_wready), .i_m_axi_bvalid(m_bvalid),
    .i_m_axi_arready(m_arready), .i_m_axi_rvalid(m_rvalid), .i_m_axi_rdata(m_rdata),
    .o_wgrant(wgrant), .o_rgrant(rgrant), .o_wbusy(wbusy), .o_rbusy(rbusy)
  );

  // Downstream AW/W handshake counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (m_awvalid && m_awready) aw_cnt++;
      if (m_wvalid && m_wready) w_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic clr;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    int a0, w0, bad;
    clr();
    resetn = 1'b0;
    // Requests and slave readies held high during reset must not leak through.
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
    #12;
    chk("rst_m_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk("rst_s_returns", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 10'b0);
    chk("rst_busy_grant", {wbusy, rbusy, wgrant, rgrant}, 4'b0);
    resetn = 1'b1;
    clr();
    tick();

    // CPU single write, minimum latency.
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b01;
    s_awaddr[31:0] = 32'h0200_2000; s_awprot[2:0] = 3'b010;
    s_wdata[31:0] = 32'hDEAD_BEEF; s_wstrb[3:0] = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    mid(); chk("wr1_idle_awvalid", m_awvalid, 0);
    tick(); mid();
    chk("wr1_awvalid_wvalid", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr1_awaddr", m_awaddr, 32'h0200_2000);
    chk("wr1_awprot", m_awprot, 3'b010);
    chk("wr1_wdata_strb", {m_wdata, m_wstrb}, {32'hDEAD_BEEF, 4'hF});
    chk("wr1_ready_up", {s_awready, s_wready}, 4'b0101);
    chk("wr1_grant_busy", {wgrant, wbusy}, 2'b01);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1;
    mid();
    chk("wr1_bvalid", s_bvalid, 2'b01);
    chk("wr1_bready_awvalid", {m_bready, m_awvalid}, 2'b10);
    tick();
    m_bvalid = 1'b0;
    mid(); chk("wr1_idle_cycle3", wbusy, 0);

    // Simultaneous write requests: round-robin from a fresh reset.
    clr(); do_reset();
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      tick(); mid();
      chk("rr_grant", wgrant, g);
      chk("rr_awready", s_awready, (g != 0) ? 2'b10 : 2'b01);
      tick();
      s_awvalid[g] = 1'b0; s_wvalid[g] = 1'b0;
      mid(); chk("rr_bvalid", s_bvalid, (g != 0) ? 2'b10 : 2'b01);
      tick();
      s_awvalid[g] = 1'b1; s_wvalid[g] = 1'b1;
    end
    clr();
    tick();

    // Requester 1 presents W two cycles ahead of AW; slave delays awready.
    a0 = aw_cnt; w0 = w_cnt;
    s_wvalid = 2'b10; s_bready = 2'b10; s_wdata[63:32] = 32'h0BAD_F00D; m_wready = 1'b1;
    mid(); chk("wfirst_idle_wready", s_wready, 0);
    tick(); tick();
    s_awvalid = 2'b10;
    tick(); mid();
    chk("wfirst_wready", s_wready, 2'b10);
    chk("wfirst_awready_low", s_awready, 0);
    tick();
    s_wvalid = '0; m_awready = 1'b1;
    mid();
    chk("wfirst_wvalid_done", m_wvalid, 0);
    chk("wfirst_awready", s_awready, 2'b10);
    tick();
    s_awvalid = '0; m_bvalid = 1'b1;
    mid(); chk("wfirst_bvalid", s_bvalid, 2'b10);
    tick();
    m_bvalid = 1'b0;
    mid();
    chk("wfirst_aw_count", aw_cnt - a0, 1);
    chk("wfirst_w_count", w_cnt - w0, 1);

    // CPU read concurrent with DMA write.
    clr();
    s_arvalid = 2'b01; s_araddr[31:0] = 32'h0100_0010; s_rready = 2'b01;
    s_awvalid = 2'b10; s_wvalid = 2'b10; s_bready = 2'b10;
    s_awaddr[63:32] = 32'h0200_3000; s_wdata[63:32] = 32'hCAFE_F00D;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    tick(); mid();
    chk("conc_grants", {rgrant, wgrant}, 2'b01);
    chk("conc_araddr", m_araddr, 32'h0100_0010);
    chk("conc_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b111);
    chk("conc_wdata", m_wdata, 32'hCAFE_F00D);
    tick();
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_bvalid = 1'b1;
    mid();
    chk("conc_rvalid", s_rvalid, 2'b01);
    chk("conc_rdata", s_rdata, 64'h0000_0000_1234_5678);
    chk("conc_bvalid", s_bvalid, 2'b10);
    tick();
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    mid(); chk("conc_done", {rbusy, wbusy}, 2'b00);

    // Slave stalls B for 10 cycles while requester 0 queues a second write.
    clr();
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b01;
    m_awready = 1'b1; m_wready = 1'b1;
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (wbusy !== 1'b1 || m_awvalid !== 1'b0 || s_awready !== 2'b00) bad++;
      tick();
    end
    chk("bstall_hold", bad, 0);
    m_bvalid = 1'b1;
    mid(); chk("bstall_bvalid", s_bvalid, 2'b01);
    tick();
    m_bvalid = 1'b0;
    mid(); chk("b2b_idle_gap", {wbusy, m_awvalid}, 2'b00);
    tick(); mid();
    chk("b2b_second_aw", {m_awvalid, wgrant}, 2'b10);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;

    // Reset pulse while requester 1 sits in W_ADDR.
    clr();
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    tick(); mid();
    chk("rstmid_pre_awvalid", {m_awvalid, wgrant}, 2'b11);
    resetn = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
    #1;
    chk("rstmid_m_valids", {m_awvalid, m_wvalid}, 2'b00);
    chk("rstmid_s_ready", {s_awready, s_wready}, 4'b0);
    chk("rstmid_busy_grant", {wbusy, wgrant}, 2'b00);
    #2;
    resetn = 1'b1;
    s_awvalid = 2'b11; s_wvalid = 2'b11;
    tick(); mid();
    chk("rstmid_tie_grant", {wgrant, wbusy}, 2'b01);
    clr();
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter_2m.md
# axi_lite_arbiter_2m

Two-requester AXI4-Lite arbiter placed in front of the single master port of the AXI4-Lite interconnect. It lets the picorv32 CPU (requester 0) and a DMA/debug engine (requester 1) share the interconnect. Independent write and read state machines grant one requester per channel using round-robin, and each grant is held until that channel's transaction completes. The downstream side connects port-for-port to the interconnect master inputs.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- Upstream vectors are flattened; requester k occupies slice [k*W +: W].
- i_s_axi_awvalid, i_s_axi_wvalid, i_s_axi_bready, i_s_axi_arvalid, i_s_axi_rready  input  2  upstream valids/readies, bit k = requester k
- i_s_axi_awaddr, i_s_axi_araddr  input  2*ADDR_WIDTH  upstream addresses
- i_s_axi_awprot, i_s_axi_arprot  input  2*3  upstream protection
- i_s_axi_wdata  input  2*DATA_WIDTH; i_s_axi_wstrb  input  2*(DATA_WIDTH/8)  upstream write data/strobe
- o_s_axi_awready, o_s_axi_wready, o_s_axi_bvalid, o_s_axi_arready, o_s_axi_rvalid  output  2  upstream handshake returns
- o_s_axi_rdata  output  2*DATA_WIDTH  upstream read data
- o_m_axi_awvalid, o_m_axi_wvalid, o_m_axi_bready, o_m_axi_arvalid, o_m_axi_rready  output  1  downstream (to interconnect)
- o_m_axi_awaddr, o_m_axi_araddr  output  ADDR_WIDTH; o_m_axi_awprot, o_m_axi_arprot  output  3
- o_m_axi_wdata  output  DATA_WIDTH; o_m_axi_wstrb  output  DATA_WIDTH/8
- i_m_axi_awready, i_m_axi_wready, i_m_axi_bvalid, i_m_axi_arready, i_m_axi_rvalid  input  1; i_m_axi_rdata  input  DATA_WIDTH
- o_wgrant, o_rgrant  output  1  current owner index (status only)
- o_wbusy, o_rbusy  output  1  channel FSM not idle

## Operation
- Write FSM: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: a request is i_s_axi_awvalid[k]. When any request is present, the grant index is registered and the FSM moves to W_ADDR.
  - Round-robin: if both request, grant the requester other than the last completed owner (wlast). Otherwise grant the sole requester.
  - W_ADDR: forward the granted AW and W channels. Sticky flags aw_done and w_done set on each downstream handshake; AW and W may complete in either order or in the same cycle. Once both are done (including handshakes in the current cycle), clear the flags and move to W_RESP.
  - W_RESP: forward B. On i_m_axi_bvalid && bready, set wlast = grant and return to W_IDLE.
- Read FSM: R_IDLE, R_ADDR, R_DATA. Same arbitration on i_s_axi_arvalid with its own rlast. R_ADDR ends on the AR handshake. R_DATA ends on the R handshake.
- Forwarding is combinational from the registered grant and state.
  - Non-granted requester: ready=0, bvalid/rvalid=0, rdata=0.
  - Downstream valids are gated by state: awvalid only in W_ADDR && !aw_done, wvalid only in W_ADDR && !w_done, bready only in W_RESP, arvalid only in R_ADDR, rready only in R_DATA.
  - Downstream payload mirrors the granted requester at all times.
- Write and read channels run concurrently. A requester may own the write channel while the other owns the read channel.
- A requester that drops awvalid/arvalid before its handshake violates AXI. This case is not checked; the FSM keeps waiting.

## Timing
- Reset (async assert, sync release):
  - States go to IDLE; grants = 0; wlast = rlast = 1, so requester 0 wins the first tie.
  - All flags are cleared.
  - All valid/ready outputs are 0; busy outputs are 0.
- Arbitration latency is 1 cycle: a request sampled in IDLE at edge N is forwarded downstream in cycle N+1.
- Minimum write: AW+W handshake in N+1, B no earlier than N+2, W_IDLE at N+3.
- Minimum read: AR in N+1, R no earlier than N+2.
- Back-to-back transactions have one IDLE cycle between them.
- Reset asserted mid-transaction abandons it immediately. Downstream valids drop asynchronously, and the interconnect/slaves are reset together with this block.
- No combinational path from i_s_* valids to o_s_* readies. All upstream readies depend only on state, grant, and downstream readies.

## Test plan
- Reset, then CPU write to 0x0200_2000 with data 0xDEADBEEF and strb 0xF; slave awready=wready=1, bvalid one cycle later -> downstream AW/W in cycle 1; requester 0 sees bvalid; o_wgrant=0; FSM back in W_IDLE in cycle 3.
- Both requesters assert awvalid in the same cycle, repeated four times -> grants alternate 0,1,0,1; the loser's awready stays 0 until its turn.
- W presented two cycles before AW by requester 1 -> wready pulses once, aw_done completes later; exactly one downstream AW and one W handshake.
- Concurrent CPU read of 0x0100_0010 (rdata 0x12345678) while DMA writes -> both complete; o_rgrant=0, o_wgrant=1; requester 0 receives rdata 0x12345678, requester 1 receives bvalid.
- Slave holds bvalid low for 10 cycles while requester 0 queues another write -> the second grant waits in W_RESP, then is issued after one IDLE cycle.
- resetn pulsed low in W_ADDR -> all outputs go to 0 immediately; after release, requester 0 wins a simultaneous request.
